uart_receiver: RTL and testbench

//  Serial-to-parallel UART receive stage, 8N1, LSB first. It consumes the line driven by the transmit stage.

---
 rtl/uart_receiver_pkg.sv | 20 ++
 rtl/uart_receiver_baud_tick.sv | 29 ++
 rtl/uart_receiver.sv | 135 +++++++++++++
 tb/tb_uart_receiver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the baud divisor
// used by both the receive and transmit stages.
package uart_defs;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   function automatic int baud_divisor(input int clock_frequency,
                                       input int baud_rate,
                                       input int oversample);
      return clock_frequency / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_receiver_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIVISOR clocks, held at zero
// while clear is asserted so the phase restarts on each start-bit detection.
module uart_baud_tick #(
   parameter int DIVISOR = 54
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int COUNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(DIVISOR - 1);

   logic [COUNT_W-1:0] count_reg;

   assign tick = !clear && (count_reg == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear || tick) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizer, mid-bit sampling FSM, shift register and
// a one-entry valid/ready holding register with framing and overrun pulses.
module uart_receiver
   import uart_defs::*;
#(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE       = 115200,
   parameter int OVERSAMPLE      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int DIVISOR  = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
   localparam int SAMPLE_W = $clog2(OVERSAMPLE);
   localparam int INDEX_W  = $clog2(DATA_BITS);
   localparam logic [SAMPLE_W-1:0] MID_SAMPLE  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(OVERSAMPLE - 1);
   localparam logic [INDEX_W-1:0]  LAST_INDEX  = INDEX_W'(DATA_BITS - 1);

   logic                 rx_meta_reg;
   logic                 rx_s;
   rx_state_t            state_reg;
   logic                 armed_reg;
   logic [SAMPLE_W-1:0]  sample_count_reg;
   logic [INDEX_W-1:0]   bit_index_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 tick;
   logic                 mid_bit;
   logic                 byte_complete;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_s        <= 1'b1;
      end else begin
         rx_meta_reg <= serial_in;
         rx_s        <= rx_meta_reg;
      end
   end

   uart_baud_tick #(
      .DIVISOR (DIVISOR)
   ) baud_tick_inst (
      .clock (clock),
      .reset (reset),
      .clear (state_reg == IDLE),
      .tick  (tick)
   );

   assign mid_bit       = tick && (sample_count_reg == MID_SAMPLE);
   assign byte_complete = (state_reg == STOP) && mid_bit && rx_s;
   assign busy          = (state_reg != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sample_count_reg <= '0;
      end else if (state_reg == IDLE) begin
         sample_count_reg <= '0;
      end else if (tick) begin
         sample_count_reg <= (sample_count_reg == LAST_SAMPLE) ? '0 : sample_count_reg + 1'b1;
      end
   end

   // The arm flag stops a held-low line (break) from re-triggering until it goes high again.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         armed_reg     <= 1'b0;
         bit_index_reg <= '0;
         shift_reg     <= '0;
         framing_error <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rx_s) begin
                  armed_reg <= 1'b1;
               end else if (armed_reg) begin
                  armed_reg <= 1'b0;
                  state_reg <= START;
               end
            end
            START: begin
               if (mid_bit) begin
                  bit_index_reg <= '0;
                  state_reg     <= rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (mid_bit) begin
                  shift_reg[bit_index_reg] <= rx_s;
                  bit_index_reg            <= bit_index_reg + 1'b1;
                  if (bit_index_reg == LAST_INDEX) begin
                     state_reg <= STOP;
                  end
               end
            end
            STOP: begin
               if (mid_bit) begin
                  framing_error <= !rx_s;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data       <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (byte_complete && (!data_valid || data_ready)) begin
            data       <= shift_reg;
            data_valid <= 1'b1;
         end else if (byte_complete) begin
            overrun <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, expected bytes
// queued on send and compared when the receiver hands them over.
module tb_uart_receiver;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 10_000;
   localparam int OS       = 16;
   localparam int BIT_CLKS = 160;

   logic       clock = 1'b0;
   logic       reset;
   logic       serial_in;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       framing_error;
   logic       overrun;
   logic       busy;

   int         vectors    = 0;
   int         miscompares = 0;
   int         fe_count   = 0;
   int         ov_count   = 0;
   logic [7:0] exp_q[$];

   always #5 clock = ~clock;

   uart_receiver #(
      .CLOCK_FREQUENCY (CLK_FREQ),
      .BAUD_RATE       (BAUD),
      .OVERSAMPLE      (OS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .serial_in     (serial_in),
      .data          (data),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun       (overrun),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", {24'd0, data}, 32'hFFFF_FFFF);
            end else begin
               logic [7:0] want;
               want = exp_q.pop_front();
               $display("rx byte %02h (expected %02h)", data, want);
               check("rx_data", {24'd0, data}, {24'd0, want});
            end
         end
         if (framing_error) fe_count++;
         if (overrun) ov_count++;
      end
   end

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks);
      serial_in = 1'b0;
      repeat (bit_clks) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         repeat (bit_clks) @(negedge clock);
      end
      serial_in = stop_bit;
      repeat (bit_clks) @(negedge clock);
      serial_in = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b, input int bit_clks);
      exp_q.push_back(b);
      send_frame(b, 1'b1, bit_clks);
      idle(20);
   endtask

   initial begin
      int fe0;
      int ov0;
      int waited;
      logic [7:0] partial;

      reset      = 1'b1;
      serial_in  = 1'b1;
      data_ready = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_data", {24'd0, data}, 32'd0);
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_fe", {31'd0, framing_error}, 32'd0);
      check("rst_ov", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      idle(20);

      // 1: two good bytes back to back
      fe0 = fe_count; ov0 = ov_count;
      send_good(8'h55, BIT_CLKS);
      send_good(8'hA3, BIT_CLKS);
      check("t1_fe", fe_count - fe0, 0);
      check("t1_ov", ov_count - ov0, 0);
      check("t1_valid_low", {31'd0, data_valid}, 32'd0);

      // 2: stop bit low, then a good byte
      fe0 = fe_count;
      send_frame(8'h3C, 1'b0, BIT_CLKS);
      idle(40);
      check("t2_fe", fe_count - fe0, 1);
      check("t2_valid", {31'd0, data_valid}, 32'd0);
      send_good(8'h81, BIT_CLKS);
      check("t2_fe_after", fe_count - fe0, 1);

      // 3: 40-clock glitch on an idle line
      fe0 = fe_count;
      serial_in = 1'b0;
      repeat (40) @(negedge clock);
      serial_in = 1'b1;
      waited = 0;
      while (busy && waited < 80) begin
         @(negedge clock);
         waited++;
      end
      check("t3_busy_clear", {31'd0, busy}, 32'd0);
      idle(20);
      check("t3_fe", fe_count - fe0, 0);
      check("t3_valid", {31'd0, data_valid}, 32'd0);

      // 4: consumer stalled, second byte overruns
      ov0 = ov_count;
      data_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, BIT_CLKS);
      idle(20);
      send_frame(8'h22, 1'b1, BIT_CLKS);
      idle(20);
      check("t4_ov", ov_count - ov0, 1);
      check("t4_held", {24'd0, data}, 32'h11);
      check("t4_valid", {31'd0, data_valid}, 32'd1);
      data_ready = 1'b1;
      repeat (2) @(negedge clock);
      check("t4_valid_clr", {31'd0, data_valid}, 32'd0);
      check("t4_queue", exp_q.size(), 0);

      // 5: reset in the middle of bit 4
      partial = 8'h7E;
      serial_in = 1'b0;
      repeat (BIT_CLKS) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         serial_in = partial[i];
         repeat (BIT_CLKS) @(negedge clock);
      end
      serial_in = partial[4];
      repeat (BIT_CLKS / 2) @(negedge clock);
      check("t5_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("t5_data", {24'd0, data}, 32'd0);
      check("t5_valid", {31'd0, data_valid}, 32'd0);
      check("t5_busy", {31'd0, busy}, 32'd0);
      serial_in = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      idle(50);
      send_good(8'h7E, BIT_CLKS);

      // 6: transmitter baud +/-3%
      fe0 = fe_count; ov0 = ov_count;
      send_good(8'hF0, 155);
      send_good(8'hF0, 165);
      check("t6_fe", fe_count - fe0, 0);
      check("t6_ov", ov_count - ov0, 0);

      idle(20);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
